// File: rtl/mario_motion.sv
// mario_motion: converts held direction keys and jump presses into a
// registered sprite position, updated once per game tick. A level-held
// move_req tells the renderer to redraw; the position is frozen until the
// renderer acknowledges it.
//
// Build option: define MARIO_WRAP_EN for horizontal wrap-around at the
// screen edges instead of clamping.
//
// state     | meaning
// ----------+------------------------------------------------
// ST_GROUND | standing on the ground, y == GROUND_Y
// ST_RISE   | jumping upward, y decreasing toward APEX_Y
// ST_FALL   | falling back down, y increasing toward GROUND_Y
module mario_motion #(
  parameter int TICK_DIV  = 833333,
  parameter int SCREEN_W  = 160,
  parameter int SPRITE_SZ = 9,
  parameter int X_START   = 10,
  parameter int GROUND_Y  = 100,
  parameter int JUMP_H    = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_jump,
  input  logic       redraw_ack,
  output logic [7:0] mar_x,
  output logic [6:0] mar_y,
  output logic       move_req,
  output logic       airborne
);

  localparam int            TW      = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TC_LAST = TW'(TICK_DIV - 1);
  localparam logic [7:0]    X_MAX   = 8'(SCREEN_W - SPRITE_SZ);
  localparam logic [7:0]    X_INIT  = 8'(X_START);
  localparam logic [6:0]    Y_GND   = 7'(GROUND_Y);
  localparam logic [6:0]    Y_APEX  = 7'(GROUND_Y - JUMP_H);

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0]    x_q, x_d;
  logic [6:0]    y_q, y_d;
  logic          move_req_q, move_req_d;
  logic          key_jump_q, key_jump_d;
  logic          jump_pend_q, jump_pend_d;
  logic          tick;
  logic          upd;

  // Tick timer, jump edge capture and redraw handshake.
  always_comb begin
    tick       = enable && (tcnt_q == TC_LAST);
    // Position work is only allowed on a tick when no redraw is outstanding.
    upd        = tick && !move_req_q;
    key_jump_d = key_jump;

    if (!enable || tcnt_q == TC_LAST) tcnt_d = '0;
    else                              tcnt_d = tcnt_q + 1'b1;

    // A tick always consumes the pending press, used or not, so presses made
    // while airborne or during a dropped frame never carry over.
    if (!enable || tick)              jump_pend_d = 1'b0;
    else if (key_jump && !key_jump_q) jump_pend_d = 1'b1;
    else                              jump_pend_d = jump_pend_q;

    // Ack has priority; since move_req is high then, the tick is skipped too.
    if (!enable)                              move_req_d = 1'b0;
    else if (move_req_q && redraw_ack)        move_req_d = 1'b0;
    else if (upd && (x_d != x_q || y_d != y_q)) move_req_d = 1'b1;
    else                                      move_req_d = move_req_q;
  end

  // Horizontal step; edges are checked before the add/subtract so x never wraps by accident.
  always_comb begin
    x_d = x_q;
    if (upd) begin
      if (key_left && !key_right) begin
        if (x_q != 8'd0) x_d = x_q - 8'd1;
`ifdef MARIO_WRAP_EN
        else             x_d = X_MAX;
`else
        else             x_d = x_q;
`endif
      end else if (key_right && !key_left) begin
        if (x_q != X_MAX) x_d = x_q + 8'd1;
`ifdef MARIO_WRAP_EN
        else              x_d = 8'd0;
`else
        else              x_d = x_q;
`endif
      end
    end
  end

  // State and position registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_GROUND;
      tcnt_q      <= '0;
      x_q         <= X_INIT;
      y_q         <= Y_GND;
      move_req_q  <= 1'b0;
      key_jump_q  <= 1'b0;
      jump_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      move_req_q  <= move_req_d;
      key_jump_q  <= key_jump_d;
      jump_pend_q <= jump_pend_d;
    end
  end

  // Jump FSM next state and vertical step.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    if (upd) begin
      case (state_q)
        ST_GROUND: begin
          if (jump_pend_q) begin
            y_d     = y_q - 7'd1;
            state_d = (y_d == Y_APEX) ? ST_FALL : ST_RISE;
          end
        end
        ST_RISE: begin
          y_d = y_q - 7'd1;
          if (y_d == Y_APEX) state_d = ST_FALL;
        end
        ST_FALL: begin
          y_d = y_q + 7'd1;
          if (y_d == Y_GND) state_d = ST_GROUND;
        end
        default: begin
          state_d = ST_GROUND;
          y_d     = Y_GND;
        end
      endcase
    end
  end

  // Outputs.
  always_comb begin
    mar_x    = x_q;
    mar_y    = y_q;
    move_req = move_req_q;
    airborne = (state_q != ST_GROUND);
  end

endmodule

// File: tb/tb_mario_motion.sv
// Directed bench for mario_motion with a short game tick (TICK_DIV=4).
// The renderer is modelled by acking each move_req two cycles after it rises.
module tb_mario_motion;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       key_left;
  logic       key_right;
  logic       key_jump;
  logic       redraw_ack;
  logic [7:0] mar_x;
  logic [6:0] mar_y;
  logic       move_req;
  logic       airborne;

  int checks = 0;
  int errors = 0;
  int jx;

  mario_motion #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .key_left   (key_left),
    .key_right  (key_right),
    .key_jump   (key_jump),
    .redraw_ack (redraw_ack),
    .mar_x      (mar_x),
    .mar_y      (mar_y),
    .move_req   (move_req),
    .airborne   (airborne)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!move_req && n < 16);
  endtask

  // One position-changing tick: check the new position, then ack it.
  task automatic move_tick(input string tag, input int ex, input int ey);
    wait_req();
    chk({tag, " req"}, move_req, 1);
    chk({tag, " x"}, mar_x, ex);
    chk({tag, " y"}, mar_y, ey);
    @(negedge clk);
    redraw_ack = 1'b1;
    @(negedge clk);
    redraw_ack = 1'b0;
    chk({tag, " ack"}, move_req, 0);
  endtask

  // A window in which no move_req may appear and the position must hold.
  task automatic idle_win(input string tag, input int ncyc, input int ex, input int ey);
    logic seen = 1'b0;
    repeat (ncyc) begin
      @(negedge clk);
      if (move_req) seen = 1'b1;
    end
    chk({tag, " req"}, seen, 0);
    chk({tag, " x"}, mar_x, ex);
    chk({tag, " y"}, mar_y, ey);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    reset = 1'b1; enable = 1'b1; key_left = 1'b0; key_right = 1'b0;
    key_jump = 1'b0; redraw_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst x", mar_x, 10);
    chk("rst y", mar_y, 100);
    chk("rst req", move_req, 0);
    chk("rst air", airborne, 0);
    reset = 1'b0;

    idle_win("idle", 40, 10, 100);
    chk("idle air", airborne, 0);

    key_right = 1'b1;
    for (int i = 1; i <= 5; i++) move_tick("right", 10 + i, 100);
    key_right = 1'b0;

    key_left = 1'b1;
    for (int i = 1; i <= 15; i++) move_tick("left", 15 - i, 100);
`ifdef MARIO_WRAP_EN
    move_tick("lwrap", 151, 100);
    move_tick("lwrap", 150, 100);
    move_tick("lwrap", 149, 100);
    for (int v = 148; v >= 0; v--) move_tick("ldown", v, 100);
`else
    idle_win("lclamp", 12, 0, 100);
`endif
    key_left  = 1'b0;
    key_right = 1'b1;

    // Ack withheld across three ticks: only one step may happen.
    wait_req();
    chk("hold req", move_req, 1);
    chk("hold x1", mar_x, 1);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (!move_req || mar_x != 8'd1) seen = 1'b1;
    end
    chk("hold frozen", seen, 0);
    redraw_ack = 1'b1;
    @(negedge clk);
    redraw_ack = 1'b0;
    chk("hold ack", move_req, 0);
    for (int v = 2; v <= 151; v++) move_tick("rup", v, 100);

`ifdef MARIO_WRAP_EN
    move_tick("rwrap", 0, 100);
    key_right = 1'b0;
    jx = 0;
`else
    idle_win("rclamp", 8, 151, 100);
    key_right = 1'b0;
    key_left  = 1'b1;
    move_tick("back", 150, 100);
    key_left  = 1'b0;
    jx = 150;
`endif

    // Jump press lands mid-tick, well clear of the tick cycle.
    key_jump = 1'b1;
    @(negedge clk);
    key_jump = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      int ey;
      ey = (i <= 30) ? 100 - i : 70 + (i - 30);
      if (i == 15) begin
        wait_req();
        chk("pause req", move_req, 1);
        chk("pause y", mar_y, 85);
        enable = 1'b0;
        seen = 1'b0;
        repeat (20) begin
          @(negedge clk);
          if (move_req) seen = 1'b1;
        end
        chk("pause reqlow", seen, 0);
        chk("pause yhold", mar_y, 85);
        chk("pause air", airborne, 1);
        enable = 1'b1;
      end else begin
        move_tick("jump", jx, ey);
      end
      chk("jump air", airborne, (i < 60) ? 1 : 0);
      if (i == 5) begin
        key_jump = 1'b1;
        @(negedge clk);
        key_jump = 1'b0;
      end
    end
    idle_win("landed", 12, jx, 100);
    chk("landed air", airborne, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mario_motion.md
# mario_motion

Player-motion stage that sits directly upstream of the screen/sprite renderer. Converts held direction/jump keys into a registered sprite position (`mar_x`, `mar_y`) once per game tick, with a ground/rise/fall jump state machine. Raises a level-held redraw request that the renderer consumes as its user-input trigger. Position stays frozen while a redraw is outstanding, so the renderer never sees coordinates change mid-draw.

## Interface
- `TICK_DIV`, 833333: clock cycles per game tick (60 Hz at 50 MHz); minimum 2.
- `SCREEN_W`, 160: screen width in pixels.
- `SPRITE_SZ`, 9: sprite edge in pixels; `X_MAX = SCREEN_W - SPRITE_SZ` (151).
- `X_START`, 10: x at reset.
- `GROUND_Y`, 100: y of sprite top when standing.
- `JUMP_H`, 30: jump apex height; `APEX_Y = GROUND_Y - JUMP_H` (70). Must be < GROUND_Y.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: game screen active; low freezes motion.
- `key_left` in 1: move left while held (active-high, already debounced).
- `key_right` in 1: move right while held.
- `key_jump` in 1: jump on rising edge.
- `redraw_ack` in 1: renderer has consumed the current position.
- `mar_x` out 8: sprite x, 0..X_MAX.
- `mar_y` out 7: sprite y, APEX_Y..GROUND_Y.
- `move_req` out 1: level, high from a position change until acked.
- `airborne` out 1: high in RISE or FALL.

## Operation
- Tick counter `tcnt` runs 0..TICK_DIV-1 and wraps. `tick` is a combinational strobe for `tcnt == TICK_DIV-1`, gated by `enable`.
- Jump capture: `key_jump` is registered once. A rising edge sets `jump_pend`. `jump_pend` clears on every tick, whether it was used or not.
- On a tick with `move_req == 0`:
  - Horizontal:
    - left only: x-1, clamped at 0.
    - right only: x+1, clamped at X_MAX.
    - both or neither: no change.
  - Vertical FSM:
    - GROUND: if `jump_pend`, go to RISE and y-1. Otherwise hold.
    - RISE: y-1. When the new y == APEX_Y, go to FALL.
    - FALL: y+1. When the new y == GROUND_Y, go to GROUND.
  - If x or y changed, set `move_req`. If nothing changed, `move_req` stays 0.
- On a tick with `move_req == 1`: x, y and FSM all hold (frame dropped). `jump_pend` still clears.
- `redraw_ack` while `move_req == 1`: clear `move_req` next edge. Ignored while `move_req == 0`.
- Ack and tick in the same cycle: the ack wins. `move_req` clears and the update is skipped for that tick.
- `enable` low:
  - `tcnt` held at 0; `move_req` cleared; `jump_pend` cleared.
  - Position and FSM held.
  - Resuming continues from the held state.
- Arithmetic: 8-bit x and 7-bit y compares are done before add/subtract, so no wrap (unless MARIO_WRAP_EN).

## Timing
- Reset values:
  - `mar_x` = X_START (10), `mar_y` = GROUND_Y (100).
  - FSM = GROUND, `move_req` = 0, `airborne` = 0.
  - `tcnt` = 0, `jump_pend` = 0.
- Latency:
  - New `mar_x`/`mar_y` and `move_req` rise on the same edge, 1 cycle after the tick cycle.
  - `move_req` falls 1 cycle after `redraw_ack` is sampled high.
- Position registers change only on tick edges; they are stable for the whole time `move_req` is high.
- With `enable` held high, the first tick occurs TICK_DIV cycles after reset deasserts.
- A full jump takes 2×JUMP_H position-changing ticks (60).

## Configuration
- `MARIO_WRAP_EN` defined: horizontal wrap-around replaces clamping.
  - Right from X_MAX goes to 0.
  - Left from 0 goes to X_MAX.
  - The move still counts as a change and sets `move_req`.
- Undefined: clamping as above. Pushing against an edge produces no change and no `move_req`.

## Test plan
Bench uses TICK_DIV=4 and acks `redraw_ack` 2 cycles after each `move_req`.
- Reset, then `enable`=1, no keys, for 40 cycles -> x=10, y=100, `move_req` never asserts.
- `key_right` held 5 ticks -> x steps 11..15, one `move_req` pulse per tick, each held until ack.
- x=0 with `key_left` held 3 ticks -> x stays 0 and no `move_req`. With MARIO_WRAP_EN: x=151 after 1 tick, then 150, 149.
- 1-cycle `key_jump` pulse mid-tick -> RISE; y falls 100→70; FALL; y rises back to 100 at tick 60. `airborne`=1 throughout, 0 after landing. A second jump press while airborne is ignored.
- Withhold ack for 3 ticks while `key_right` is held -> x advances once only, then resumes +1 per tick after the ack.
- `enable` dropped mid-jump at y=85 for 20 cycles -> y stays 85 and `move_req`=0. On re-enable the jump continues from 85.
